ldm_stm_sequencer: RTL and testbench

- Parametrised successor to the combinational LDM/STM register-address generator.
- Takes a block-transfer register list, base address and ARM P/U addressing bits, then sequences one register/memory-address pair per accepted beat.
- Provides a start/busy/done handshake, memory back-pressure stall and a transfer count.
- Sits between the decode stage and the register-file/memory-interface in the multi-cycle LDM/STM path.

---
 rtl/ldm_stm_pkg.sv | 29 ++
 rtl/lowest_set_bit_encoder.sv | 26 ++
 rtl/ldm_stm_sequencer.sv | 138 +++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_pkg.sv
// Shared types, constants and helpers for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Addressing mode, encoded as {P, U}.
    typedef enum logic [1:0] {
        DA = 2'b00,
        IA = 2'b01,
        DB = 2'b10,
        IB = 2'b11
    } mode_t;

    localparam int unsigned DEF_WORD_BYTES = 4;
    localparam int unsigned POPCOUNT_MAX_W = 64;

    function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] v);
        int unsigned c = 0;
        for (int unsigned i = 0; i < POPCOUNT_MAX_W; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Priority encoder: index of the lowest set bit, plus the mask with that bit removed.
module lowest_set_bit_encoder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mask,
    output logic [IDX_W-1:0] index,
    output logic             valid,
    output logic [WIDTH-1:0] mask_cleared
);

    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (mask[i] && !valid) begin
                index = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit.
    assign mask_cleared = mask & (mask - WIDTH'(1));

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-cycle LDM/STM register/address sequencer with start/busy/done handshake.
// Optional writeback-address outputs are enabled by defining LDM_STM_WRITEBACK_EN.
module ldm_stm_sequencer
    import ldm_stm_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned REG_AW     = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_BYTES = DEF_WORD_BYTES,
    parameter int unsigned CNT_W      = 5
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                start_in,
    input  logic [NUM_REGS-1:0] reg_list_in,
    input  logic [ADDR_W-1:0]   base_addr_in,
    input  logic                up_in,
    input  logic                pre_in,
    input  logic                mem_ready_in,
    output logic [REG_AW-1:0]   reg_addr_out,
    output logic [ADDR_W-1:0]   mem_addr_out,
    output logic                xfer_valid_out,
    output logic                last_out,
    output logic                busy_out,
    output logic                done_out,
    output logic [CNT_W-1:0]    count_out
`ifdef LDM_STM_WRITEBACK_EN
    ,
    output logic [ADDR_W-1:0]   wb_addr_out,
    output logic                wb_valid_out
`endif
);

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [REG_AW-1:0]   enc_index;
    logic                enc_valid;
    logic [NUM_REGS-1:0] enc_cleared;

    logic [CNT_W-1:0]    start_count;
    logic [ADDR_W-1:0]   span;
    logic [ADDR_W-1:0]   start_addr;
    logic                last_beat;
    mode_t               mode;

    lowest_set_bit_encoder #(
        .WIDTH (NUM_REGS),
        .IDX_W (REG_AW)
    ) u_lsb (
        .mask         (mask_q),
        .index        (enc_index),
        .valid        (enc_valid),
        .mask_cleared (enc_cleared)
    );

    // Lowest register always takes the lowest address, so decrementing modes
    // start at the bottom of the block and the sequence always walks upward.
    always_comb begin
        start_count = CNT_W'(popcount(POPCOUNT_MAX_W'(reg_list_in)));
        span        = ADDR_W'(start_count) * ADDR_W'(WORD_BYTES);
        mode        = mode_t'({pre_in, up_in});
        case (mode)
            IA:      start_addr = base_addr_in;
            IB:      start_addr = base_addr_in + ADDR_W'(WORD_BYTES);
            DA:      start_addr = base_addr_in - span + ADDR_W'(WORD_BYTES);
            default: start_addr = base_addr_in - span;
        endcase
    end

    assign last_beat = (state_q == RUN) && enc_valid && (enc_cleared == '0);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    mask_d  = reg_list_in;
                    addr_d  = start_addr;
                    count_d = start_count;
                    state_d = (start_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (mem_ready_in) begin
                    mask_d = enc_cleared;
                    addr_d = addr_q + ADDR_W'(WORD_BYTES);
                    if (last_beat) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign reg_addr_out   = enc_index;
    assign mem_addr_out   = addr_q;
    assign xfer_valid_out = (state_q == RUN);
    assign last_out       = last_beat;
    assign busy_out       = (state_q != IDLE);
    assign done_out       = (state_q == DONE);
    assign count_out      = count_q;

`ifdef LDM_STM_WRITEBACK_EN
    logic [ADDR_W-1:0] wb_addr_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wb_addr_q <= '0;
        end else if (state_q == IDLE && start_in) begin
            wb_addr_q <= up_in ? (base_addr_in + span) : (base_addr_in - span);
        end
    end

    assign wb_addr_out  = wb_addr_q;
    assign wb_valid_out = (state_q == DONE);
`endif

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Randomized self-checking bench for ldm_stm_sequencer against a transaction-level model.
module tb_ldm_stm_sequencer;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        start_in = 1'b0;
    logic [15:0] reg_list_in = '0;
    logic [31:0] base_addr_in = '0;
    logic        up_in = 1'b0;
    logic        pre_in = 1'b0;
    logic        mem_ready_in = 1'b0;
    logic [3:0]  reg_addr_out;
    logic [31:0] mem_addr_out;
    logic        xfer_valid_out;
    logic        last_out;
    logic        busy_out;
    logic        done_out;
    logic [4:0]  count_out;
`ifdef LDM_STM_WRITEBACK_EN
    logic [31:0] wb_addr_out;
    logic        wb_valid_out;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    ldm_stm_sequencer #(
        .NUM_REGS   (16),
        .REG_AW     (4),
        .ADDR_W     (32),
        .WORD_BYTES (4),
        .CNT_W      (5)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .start_in       (start_in),
        .reg_list_in    (reg_list_in),
        .base_addr_in   (base_addr_in),
        .up_in          (up_in),
        .pre_in         (pre_in),
        .mem_ready_in   (mem_ready_in),
        .reg_addr_out   (reg_addr_out),
        .mem_addr_out   (mem_addr_out),
        .xfer_valid_out (xfer_valid_out),
        .last_out       (last_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .count_out      (count_out)
`ifdef LDM_STM_WRITEBACK_EN
        ,
        .wb_addr_out    (wb_addr_out),
        .wb_valid_out   (wb_valid_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_seq(input logic [15:0] list, input logic [31:0] base,
                           input logic up, input logic pre,
                           input int unsigned ready_pct, input int unsigned stall_first);
        int unsigned regs[$];
        int unsigned n, k, cycles, stalls, stalled;
        logic [31:0] first_addr, wb_exp;
        logic        rdy;

        for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
        n = regs.size();
        if (up) first_addr = pre ? base + 32'd4 : base;
        else    first_addr = pre ? base - 32'(4*n) : base - 32'(4*n) + 32'd4;
        wb_exp = up ? base + 32'(4*n) : base - 32'(4*n);

        check("idle_busy", busy_out, 0);
        check("idle_valid", xfer_valid_out, 0);
        reg_list_in  = list;
        base_addr_in = base;
        up_in        = up;
        pre_in       = pre;
        start_in     = 1'b1;
        @(negedge clk_in);
        start_in     = 1'b0;
        reg_list_in  = 16'($urandom);
        base_addr_in = $urandom;
        up_in        = 1'($urandom);
        pre_in       = 1'($urandom);
        check("count", count_out, n);

        k = 0; cycles = 0; stalls = 0; stalled = 0;
        while (k < n && cycles < 500) begin
            check("valid", xfer_valid_out, 1);
            check("reg", reg_addr_out, regs[k]);
            check("addr", mem_addr_out, first_addr + 32'(4*k));
            check("last", last_out, (k == n - 1));
            check("busy", busy_out, 1);
            check("done_early", done_out, 0);
            if (k == 0 && stalled < stall_first) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = ($urandom_range(1, 100) <= ready_pct);
            end
            mem_ready_in = rdy;
            start_in     = 1'($urandom);
            reg_list_in  = 16'($urandom);
            @(negedge clk_in);
            start_in = 1'b0;
            if (rdy) k++;
            else     stalls++;
            cycles++;
        end
        check("beats_done", k, n);
        check("latency", cycles, n + stalls);

        check("done_valid", xfer_valid_out, 0);
        check("done_pulse", done_out, 1);
        check("done_busy", busy_out, 1);
`ifdef LDM_STM_WRITEBACK_EN
        check("wb_valid", wb_valid_out, 1);
        check("wb_addr", wb_addr_out, wb_exp);
`else
        if (wb_exp === 32'hx) check("wb_unknown", wb_exp, 0);
`endif
        start_in     = 1'($urandom);
        mem_ready_in = 1'($urandom);
        @(negedge clk_in);
        start_in = 1'b0;
        check("post_done", done_out, 0);
        check("post_busy", busy_out, 0);
        check("count_hold", count_out, n);
    endtask

    task automatic reset_mid_seq();
        reg_list_in  = 16'hFFFF;
        base_addr_in = 32'h4000;
        up_in        = 1'b1;
        pre_in       = 1'b0;
        mem_ready_in = 1'b1;
        start_in     = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        check("rst_beat0", reg_addr_out, 0);
        @(negedge clk_in);
        check("rst_beat1", reg_addr_out, 1);
        check("rst_beat1_addr", mem_addr_out, 32'h4004);
        reset_in = 1'b0;
        #1;
        check("rst_valid", xfer_valid_out, 0);
        check("rst_last", last_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_reg", reg_addr_out, 0);
        check("rst_addr", mem_addr_out, 0);
        check("rst_count", count_out, 0);
`ifdef LDM_STM_WRITEBACK_EN
        check("rst_wb", wb_addr_out, 0);
`endif
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            check("rst_idle_valid", xfer_valid_out, 0);
            check("rst_idle_busy", busy_out, 0);
        end
    endtask

    initial begin
        mem_ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("init_valid", xfer_valid_out, 0);
        check("init_busy", busy_out, 0);
        check("init_done", done_out, 0);
        check("init_addr", mem_addr_out, 0);
        check("init_count", count_out, 0);
        @(negedge clk_in);
        reset_in = 1'b1;
        @(negedge clk_in);

        run_seq(16'h8005, 32'h1000, 1'b1, 1'b0, 100, 0);
        run_seq(16'h00F0, 32'h2000, 1'b0, 1'b1, 100, 0);
        run_seq(16'h0003, 32'hFFFF_FFFC, 1'b1, 1'b1, 100, 0);
        run_seq(16'h0006, 32'h0000_0100, 1'b0, 1'b0, 100, 3);
        run_seq(16'h0000, 32'h0000_3000, 1'b1, 1'b0, 100, 0);
        reset_mid_seq();
        for (int t = 0; t < 40; t++) begin
            logic [15:0] lst;
            lst = 16'($urandom);
            if (t % 3 == 1) lst = lst & 16'($urandom) & 16'($urandom);
            run_seq(lst, $urandom, 1'($urandom), 1'($urandom), 60, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
